gmii_rx_checker: RTL

Receive-side frame checker in the `gmii_rx_clk` domain, placed directly upstream of the asynchronous receive FIFO stage. It passes the GMII stream through with one cycle of latency. For each frame it also validates preamble/SFD, line errors, length and Ethernet FCS (CRC-32). It reports a per-frame status pulse plus saturating statistics counters.

---
 rtl/gmii_rx_checker.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_checker.sv
// GMII receive frame checker: one-cycle registered passthrough plus per-frame
// preamble/SFD, line-error, length and FCS validation with saturating statistics.
module gmii_rx_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  gmii_rxd_o,
    output logic        gmii_rx_dv_o,
    output logic        gmii_rx_er_o,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_len,
    output logic [31:0] cnt_good,
    output logic [31:0] cnt_crc_err,
    output logic [31:0] cnt_len_err,
    output logic [31:0] cnt_other_err
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, ERR_WAIT} state_e;
    typedef enum logic [1:0] {RES_GOOD, RES_CRC, RES_LEN, RES_OTHER} result_e;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFFFFFF) ? value : value + 32'd1;
    endfunction

    state_e      state, state_next, pre_state;
    result_e     result;
    logic        err_flag, err_next, pre_err;
    logic [15:0] len_cnt, len_next;
    logic [31:0] crc, crc_next;
    logic        dv_prev, frame_start, frame_end;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            gmii_rxd_o   <= '0;
            gmii_rx_dv_o <= 1'b0;
            gmii_rx_er_o <= 1'b0;
        end else begin
            gmii_rxd_o   <= gmii_rxd;
            gmii_rx_dv_o <= gmii_rx_dv;
            gmii_rx_er_o <= gmii_rx_er;
        end
    end

    assign frame_start = gmii_rx_dv && !dv_prev;

    // Preamble rules, shared by the frame-start byte and later preamble bytes.
    always_comb begin
        pre_state = ERR_WAIT;
        pre_err   = 1'b1;
        if (!gmii_rx_er) begin
            if (gmii_rxd == PRE_BYTE) begin
                pre_state = PREAMBLE;
                pre_err   = 1'b0;
            end else if (gmii_rxd == SFD_BYTE) begin
                pre_state = DATA;
                pre_err   = 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        err_next   = err_flag;
        len_next   = len_cnt;
        crc_next   = crc;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = pre_state;
                    err_next   = pre_err;
                    len_next   = '0;
                    crc_next   = CRC_INIT;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = pre_state;
                    err_next   = err_flag | pre_err;
                end
            end
            DATA: begin
                if (!gmii_rx_dv) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end else if (gmii_rx_er) begin
                    err_next   = 1'b1;
                    state_next = ERR_WAIT;
                end else begin
                    if (len_cnt != 16'hFFFF) len_next = len_cnt + 16'd1;
                    crc_next = crc_byte(crc, gmii_rxd);
                end
            end
            ERR_WAIT: begin
                if (!gmii_rx_dv) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // End-of-frame classification; earlier checks take priority.
    always_comb begin
        if (err_flag || state == PREAMBLE) begin
            result = RES_OTHER;
        end else if (len_cnt < MIN_L || len_cnt > MAX_L) begin
            result = RES_LEN;
        end else if (crc != CRC_RESIDUE) begin
            result = RES_CRC;
        end else begin
            result = RES_GOOD;
        end
    end

    // dv_prev resets high so a frame already in flight at reset release is ignored.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_flag <= 1'b0;
            len_cnt  <= '0;
            crc      <= CRC_INIT;
            dv_prev  <= 1'b1;
        end else begin
            state    <= state_next;
            err_flag <= err_next;
            len_cnt  <= len_next;
            crc      <= crc_next;
            dv_prev  <= gmii_rx_dv;
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            frame_len     <= '0;
            cnt_good      <= '0;
            cnt_crc_err   <= '0;
            cnt_len_err   <= '0;
            cnt_other_err <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_ok  <= (result == RES_GOOD);
                frame_len <= len_cnt;
                case (result)
                    RES_GOOD:  cnt_good      <= sat_inc(cnt_good);
                    RES_CRC:   cnt_crc_err   <= sat_inc(cnt_crc_err);
                    RES_LEN:   cnt_len_err   <= sat_inc(cnt_len_err);
                    default:   cnt_other_err <= sat_inc(cnt_other_err);
                endcase
            end
        end
    end

endmodule
